// File: rtl/obs_subproduct_gen_93bit_if.sv
// Operand/result handshake bundle for the OBS sub-product generator.
// The slave side is the generator; the master side feeds operands and consumes p1..p4.
interface obs_subproduct_gen_93bit_if #(
   parameter int W = 93
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] p1;
   logic [W-1:0] p2;
   logic [W-1:0] p3;
   logic [W-1:0] p4;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p1, p2, p3, p4
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p1, p2, p3, p4
   );
endinterface

// File: rtl/obs_subproduct_gen_93bit.sv
// Digit-serial GF(2) sub-product generator for the 93-bit OBS multiplier.
// Operands are split into even/odd coefficient halves; four carry-free
// half-products (Ae*Be, Ae*Bo, Ao*Be, Ao*Bo) are accumulated DIGIT b-bits
// per cycle and handed to the overlap stage on p1..p4.
module obs_subproduct_gen_93bit #(
   parameter int N     = 94,
   parameter int HALF  = N / 2,
   parameter int DIGIT = 4
) (
   input logic                       clk,
   input logic                       rst_n,
   obs_subproduct_gen_93bit_if.slave bus
);
   localparam int W    = N - 1;
   localparam int NCYC = (HALF + DIGIT - 1) / DIGIT;
   localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam int NL   = 4;
   localparam int SW   = 16;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   // index 0 = even coefficients, index 1 = odd coefficients
   logic [1:0][HALF-1:0]   ah_q, ah_d, bh_q, bh_d;
   logic [1:0][HALF-1:0]   a_split, b_split;
   logic [NL-1:0][W-1:0]   p_q, p_d, acc_nxt;
   logic [2*HALF-1:0]      a_pad, b_pad;
   logic [SW-1:0]          base;
   logic                   in_ready, out_valid;

   // zero-extend so the top odd coefficient (beyond bit W-1) reads as 0
   assign a_pad = (2*HALF)'(bus.a);
   assign b_pad = (2*HALF)'(bus.b);

   // first b-coefficient index consumed this cycle
   assign base = SW'(cnt_q) * SW'(DIGIT);

   // even/odd split of the incoming operands
   always_comb begin
      a_split = '0;
      b_split = '0;
      for (int i = 0; i < HALF; i++) begin
         a_split[0][i] = a_pad[2*i];
         a_split[1][i] = a_pad[2*i+1];
         b_split[0][i] = b_pad[2*i];
         b_split[1][i] = b_pad[2*i+1];
      end
   end

   // lane l multiplies a-half l/2 by b-half l%2; indices past HALF-1 shift
   // out to zero, which handles the short final digit for free
   for (genvar l = 0; l < NL; l++) begin : g_lane
      logic [W-1:0] acc;
      // one digit step of the XOR shift-accumulate
      always_comb begin
         acc = p_q[l];
         for (int j = 0; j < DIGIT; j++) begin
            if (|((bh_q[l%2] >> (base + SW'(j))) & HALF'(1)))
               acc = acc ^ (W'(ah_q[l/2]) << (base + SW'(j)));
         end
      end
      assign acc_nxt[l] = acc;
   end

   // next-state, datapath update and handshake outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ah_d      = ah_q;
      bh_d      = bh_q;
      p_d       = p_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               ah_d    = a_split;
               bh_d    = b_split;
               p_d     = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            p_d = acc_nxt;
            if (cnt_q == CW'(NCYC - 1)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            // return to IDLE without sampling in_valid this cycle
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ah_q    <= '0;
         bh_q    <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ah_q    <= ah_d;
         bh_q    <= bh_d;
         p_q     <= p_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.p1        = p_q[0];
   assign bus.p2        = p_q[1];
   assign bus.p3        = p_q[2];
   assign bus.p4        = p_q[3];
endmodule

// File: tb/tb_obs_subproduct_gen_93bit.sv
// Bench for the OBS sub-product generator: directed cases, random operands
// with random back-pressure, in_valid pokes while busy, and reset mid-run.
module tb_obs_subproduct_gen_93bit;
   localparam int W    = 93;
   localparam int PW   = 187;
   localparam int NCYC = 12;

   logic clk = 1'b0;
   logic rst_n;
   int   ncmp = 0;
   int   nerr = 0;
   logic [W-1:0] lp1, lp2, lp3, lp4;

   obs_subproduct_gen_93bit_if #(.W(W)) bus ();

   obs_subproduct_gen_93bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd93();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   // full carry-free product of two 93-bit polynomials
   function automatic logic [PW-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [PW-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++)
         if (y[i]) r = r ^ (PW'(x) << i);
      return r;
   endfunction

   function automatic logic [46:0] evn(input logic [W-1:0] x);
      logic [46:0] r;
      r = '0;
      for (int i = 0; i < 47; i++) r[i] = x[2*i];
      return r;
   endfunction

   function automatic logic [46:0] odd(input logic [W-1:0] x);
      logic [46:0] r;
      r = '0;
      for (int i = 0; i < 46; i++) r[i] = x[2*i+1];
      return r;
   endfunction

   function automatic logic [W-1:0] hmul(input logic [46:0] u, input logic [46:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < 47; i++)
         if (v[i]) r = r ^ (W'(u) << i);
      return r;
   endfunction

   // what overlap_module does: a = Ae(x^2) + x*Ao(x^2), likewise b
   function automatic logic [PW-1:0] overlap(input logic [W-1:0] q1, input logic [W-1:0] q2,
                                             input logic [W-1:0] q3, input logic [W-1:0] q4);
      logic [PW-1:0] r;
      r = '0;
      for (int k = 0; k < W; k++) begin
         r[2*k]   = r[2*k]   ^ q1[k];
         r[2*k+1] = r[2*k+1] ^ q2[k] ^ q3[k];
         r[2*k+2] = r[2*k+2] ^ q4[k];
      end
      return r;
   endfunction

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int low_pct, input bit poke);
      logic [W-1:0] e1, e2, e3, e4, h1, h2, h3, h4;
      int cyc;
      bit ir_bad, unstable;
      e1 = hmul(evn(av), evn(bv));
      e2 = hmul(evn(av), odd(bv));
      e3 = hmul(odd(av), evn(bv));
      e4 = hmul(odd(av), odd(bv));
      for (int t = 0; t < 40 && bus.in_ready !== 1'b1; t++) @(negedge clk);
      chk("accept_ready", PW'(bus.in_ready), PW'(1));
      bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.a = rnd93(); bus.b = rnd93();
      cyc = 0; ir_bad = 0;
      while (cyc < NCYC + 8) begin
         cyc++;
         if (poke && cyc == 2) begin
            bus.in_valid = 1'b1; bus.a = rnd93(); bus.b = rnd93();
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (bus.out_valid === 1'b1) break;
         if (bus.in_ready !== 1'b0) ir_bad = 1;
      end
      chk("latency", PW'(cyc), PW'(NCYC));
      chk("busy_in_ready", PW'(ir_bad), PW'(0));
      chk("done_in_ready", PW'(bus.in_ready), PW'(0));
      chk("p1", PW'(bus.p1), PW'(e1));
      chk("p2", PW'(bus.p2), PW'(e2));
      chk("p3", PW'(bus.p3), PW'(e3));
      chk("p4", PW'(bus.p4), PW'(e4));
      chk("product", overlap(bus.p1, bus.p2, bus.p3, bus.p4), clmul(av, bv));
      h1 = bus.p1; h2 = bus.p2; h3 = bus.p3; h4 = bus.p4;
      lp1 = h1; lp2 = h2; lp3 = h3; lp4 = h4;
      unstable = 0;
      for (int t = 0; t < 40; t++) begin
         bus.out_ready = (t >= 20) || ($urandom_range(0, 99) >= low_pct);
         // offer a new operand in the ack cycle; it must not be taken
         bus.in_valid = bus.out_ready;
         bus.a = rnd93(); bus.b = rnd93();
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (bus.out_ready) break;
         if (bus.out_valid !== 1'b1 || bus.p1 !== h1 || bus.p2 !== h2 ||
             bus.p3 !== h3 || bus.p4 !== h4) unstable = 1;
      end
      bus.out_ready = 1'b0;
      chk("hold_stable", PW'(unstable), PW'(0));
      chk("ack_out_valid", PW'(bus.out_valid), PW'(0));
      chk("ack_no_accept", PW'(bus.in_ready), PW'(1));
   endtask

   initial begin
      logic [W-1:0] one, ra, rb;
      one = 1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", PW'(bus.in_ready), PW'(1));
      chk("rst_out_valid", PW'(bus.out_valid), PW'(0));
      chk("rst_p", PW'({bus.p1, bus.p2} | PW'({bus.p3, bus.p4})), PW'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run_op(one, one, 0, 0);
      chk("t1_p1", PW'(lp1), PW'(1));
      chk("t1_rest", PW'(lp2 | lp3 | lp4), PW'(0));
      run_op(W'(3), W'(3), 0, 0);
      chk("t2_p", PW'({lp1, lp2} ^ PW'({lp3, lp4})), PW'(0));
      chk("t2_p4", PW'(lp4), PW'(1));
      chk("t2_overlap", overlap(lp1, lp2, lp3, lp4), PW'(5));
      run_op(one << 92, one << 92, 0, 0);
      chk("t3_p1", PW'(lp1), PW'(one) << 92);
      chk("t3_rest", PW'(lp2 | lp3 | lp4), PW'(0));
      run_op(one << 91, one << 91, 0, 0);
      chk("t3b_p4", PW'(lp4), PW'(one) << 90);
      chk("t3b_rest", PW'(lp1 | lp2 | lp3), PW'(0));
      run_op('1, '1, 0, 1);
      run_op('0, rnd93(), 30, 0);

      for (int n = 0; n < 150; n++)
         run_op(rnd93(), rnd93(), 30, ($urandom_range(0, 3) == 0));

      // reset in the middle of a computation
      ra = rnd93(); rb = rnd93();
      bus.a = ra | one; bus.b = rb | one; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_busy", PW'(bus.in_ready), PW'(0));
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", PW'(bus.out_valid), PW'(0));
      chk("mid_rst_in_ready", PW'(bus.in_ready), PW'(1));
      chk("mid_rst_p", PW'({bus.p1, bus.p2} | PW'({bus.p3, bus.p4})), PW'(0));
      rst_n = 1'b1;
      @(negedge clk);
      run_op(one, one, 0, 0);
      chk("post_rst_p1", PW'(lp1), PW'(1));
      chk("post_rst_rest", PW'(lp2 | lp3 | lp4), PW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
